// File: rtl/audio_sample_player.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_player
// Description : Receiving end of the game-event audio interface. A one-cycle
//               TRIGGER selects a sample; its start address and length are
//               read from a descriptor table in the shared sample ROM. The
//               8-bit unsigned sample bytes are then streamed at a fixed rate
//               of one byte every CLK_DIV clocks. The current byte drives a
//               1-bit PWM speaker output.
//
// Ports       : CLK           system clock
//               RESET         synchronous, active-high reset
//               SAMPLE_SELECT sample index, used only while TRIGGER is high
//               TRIGGER       one-cycle start pulse (also restarts playback)
//               ROM_ADDR      registered sample ROM address
//               ROM_DATA      ROM read data, one cycle after ROM_ADDR
//               SAMPLE_OUT    current unsigned sample, 0x80 = silence
//               AUDIO_PWM     PWM speaker drive, duty = SAMPLE_OUT/256
//               BUSY          high while fetching a descriptor or playing
//
// Revision    : 1.0  initial release
// ============================================================================
module audio_sample_player #(
    parameter int SAMPLE_BITS = 4,
    parameter int ADDR_BITS   = 16,
    parameter int DESC_BASE   = 0,
    parameter int CLK_DIV     = 3125
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [SAMPLE_BITS-1:0] SAMPLE_SELECT,
    input  logic                   TRIGGER,
    output logic [ADDR_BITS-1:0]   ROM_ADDR,
    input  logic [7:0]             ROM_DATA,
    output logic [7:0]             SAMPLE_OUT,
    output logic                   AUDIO_PWM,
    output logic                   BUSY
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_rate_w  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0]  c_silence = 8'h80;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    state_t                r_state;

    // Descriptor fetch: r_fetch_cnt counts the cycles spent in FETCH. The
    // address for byte n is on ROM_ADDR in cycle n, its data arrives on
    // ROM_DATA in cycle n+1, so captures lag the address sequence by one.
    logic [2:0]            r_fetch_cnt;
    logic [7:0]            r_start_hi;
    logic [7:0]            r_start_lo;
    logic [7:0]            r_len_hi;

    // Playback
    logic [15:0]           r_remaining;
    logic [c_rate_w-1:0]   r_rate;

    // PWM
    logic [7:0]            r_pwm_cnt;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [ADDR_BITS-1:0]  w_desc_addr;
    logic [15:0]           w_start;
    logic [15:0]           w_length;
    logic                  w_tick;
    logic                  w_end_tick;

    // Descriptor index is scaled by 4 and wrapped to the ROM address width.
    assign w_desc_addr = ADDR_BITS'(DESC_BASE)
                       + (ADDR_BITS'(SAMPLE_SELECT) << 2);

    // The final length byte is used straight off ROM_DATA in the last fetch
    // cycle so that PLAY can begin without an extra capture cycle.
    assign w_start  = {r_start_hi, r_start_lo};
    assign w_length = {r_len_hi, ROM_DATA};

    assign w_tick     = (r_rate == c_rate_w'(CLK_DIV - 1));
    assign w_end_tick = (r_state == ST_PLAY) && w_tick && (r_remaining == 16'd0);

    // ------------------------------------------------------------------------
    // PWM generator: free-running 8-bit counter compared against the sample.
    // Independent of the playback FSM so the tone never glitches on retrigger.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pwm_cnt <= 8'd0;
            AUDIO_PWM <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            AUDIO_PWM <= (r_pwm_cnt < SAMPLE_OUT);
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM: IDLE -> FETCH -> PLAY -> IDLE
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_fetch_cnt <= 3'd0;
            r_start_hi  <= 8'd0;
            r_start_lo  <= 8'd0;
            r_len_hi    <= 8'd0;
            r_remaining <= 16'd0;
            r_rate      <= '0;
            ROM_ADDR    <= '0;
            SAMPLE_OUT  <= c_silence;
            BUSY        <= 1'b0;
        end else if (TRIGGER) begin
            // A trigger in any state restarts the descriptor fetch. The sample
            // output keeps its value until the new sample's first tick, except
            // when this cycle is also the old sample's end tick: that tick
            // still returns the output to silence.
            r_state     <= ST_FETCH;
            r_fetch_cnt <= 3'd0;
            ROM_ADDR    <= w_desc_addr;
            BUSY        <= 1'b1;
            if (w_end_tick) begin
                SAMPLE_OUT <= c_silence;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    BUSY <= 1'b0;
                end

                ST_FETCH: begin
                    r_fetch_cnt <= r_fetch_cnt + 3'd1;

                    // Walk the four descriptor bytes.
                    if (r_fetch_cnt < 3'd3) begin
                        ROM_ADDR <= ROM_ADDR + ADDR_BITS'(1);
                    end

                    case (r_fetch_cnt)
                        3'd1: r_start_hi <= ROM_DATA;
                        3'd2: r_start_lo <= ROM_DATA;
                        3'd3: r_len_hi   <= ROM_DATA;
                        3'd4: begin
                            if (w_length == 16'd0) begin
                                // Empty sample: nothing to play, leave the
                                // address where the fetch left it.
                                r_state <= ST_IDLE;
                                BUSY    <= 1'b0;
                            end else begin
                                // Point at the first byte now; with
                                // CLK_DIV >= 4 its data is on ROM_DATA well
                                // before the first tick.
                                r_state     <= ST_PLAY;
                                ROM_ADDR    <= ADDR_BITS'(w_start);
                                r_remaining <= w_length;
                                r_rate      <= '0;
                            end
                        end
                        default: ;
                    endcase
                end

                ST_PLAY: begin
                    if (w_tick) begin
                        r_rate <= '0;
                        if (r_remaining != 16'd0) begin
                            // ROM_DATA holds the prefetched byte at the
                            // current pointer; advance to prefetch the next.
                            SAMPLE_OUT  <= ROM_DATA;
                            ROM_ADDR    <= ROM_ADDR + ADDR_BITS'(1);
                            r_remaining <= r_remaining - 16'd1;
                        end else begin
                            // Last byte has been held a full period.
                            SAMPLE_OUT <= c_silence;
                            r_state    <= ST_IDLE;
                            BUSY       <= 1'b0;
                        end
                    end else begin
                        r_rate <= r_rate + c_rate_w'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_player.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_audio_sample_player
// Description : Directed self-checking bench for audio_sample_player. A
//               behavioural ROM with one cycle of read latency holds the
//               descriptor table and sample data; expected values are
//               hand-derived cycle positions relative to the trigger cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_audio_sample_player;

    localparam int SAMPLE_BITS = 4;
    localparam int ADDR_BITS   = 16;
    localparam int DESC_BASE   = 0;
    localparam int CLK_DIV     = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        TRIGGER = 1'b0;
    logic [3:0]  SAMPLE_SELECT = 4'd0;
    logic [15:0] ROM_ADDR;
    logic [7:0]  ROM_DATA;
    logic [7:0]  SAMPLE_OUT;
    logic        AUDIO_PWM;
    logic        BUSY;

    logic [7:0]  rom [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    // Synchronous ROM: data is mem[address of the previous cycle].
    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

    audio_sample_player #(
        .SAMPLE_BITS (SAMPLE_BITS),
        .ADDR_BITS   (ADDR_BITS),
        .DESC_BASE   (DESC_BASE),
        .CLK_DIV     (CLK_DIV)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .SAMPLE_SELECT (SAMPLE_SELECT),
        .TRIGGER       (TRIGGER),
        .ROM_ADDR      (ROM_ADDR),
        .ROM_DATA      (ROM_DATA),
        .SAMPLE_OUT    (SAMPLE_OUT),
        .AUDIO_PWM     (AUDIO_PWM),
        .BUSY          (BUSY)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pulse TRIGGER during the current cycle T; returns in cycle T+1 with a
    // junk select value on the bus to show it is ignored.
    task automatic trig(input logic [3:0] sel);
        TRIGGER       = 1'b1;
        SAMPLE_SELECT = sel;
        tick();
        TRIGGER       = 1'b0;
        SAMPLE_SELECT = 4'($urandom);
    endtask

    function automatic logic [7:0] exp_sel2(input int k);
        if (k < 10)      return 8'h80;
        else if (k < 14) return 8'h10;
        else if (k < 18) return 8'h20;
        else if (k < 22) return 8'h30;
        else             return 8'h80;
    endfunction

    // Full playback of descriptor 2 (start 0x100, bytes 10/20/30).
    task automatic play_sel2(input string tag);
        trig(4'd2);
        for (int k = 1; k <= 22; k++) begin
            if (k <= 4)
                check($sformatf("%s rom_addr T+%0d", tag, k), 32'(ROM_ADDR), 32'(8 + k - 1));
            check($sformatf("%s busy T+%0d", tag, k), 32'(BUSY), 32'(k <= 21));
            check($sformatf("%s sample T+%0d", tag, k), 32'(SAMPLE_OUT), 32'(exp_sel2(k)));
            if (k < 22) tick();
        end
    endtask

    initial begin
        int viol;
        int drops;
        int cnt;

        for (int a = 0; a < 65536; a++) rom[a] = 8'h00;
        // Descriptors: {start_hi, start_lo, len_hi, len_lo}
        rom[4]  = 8'h03; rom[5]  = 8'h00; rom[6]  = 8'h00; rom[7]  = 8'h00; // 1: len 0
        rom[8]  = 8'h01; rom[9]  = 8'h00; rom[10] = 8'h00; rom[11] = 8'h03; // 2
        rom[12] = 8'h02; rom[13] = 8'h00; rom[14] = 8'h00; rom[15] = 8'h02; // 3
        rom[16] = 8'hFF; rom[17] = 8'hFF; rom[18] = 8'h00; rom[19] = 8'h02; // 4: wraps
        rom[20] = 8'h03; rom[21] = 8'h00; rom[22] = 8'h00; rom[23] = 8'h80; // 5: 0x40s
        rom[24] = 8'h04; rom[25] = 8'h00; rom[26] = 8'h00; rom[27] = 8'h80; // 6: 0x00s
        rom[16'h0100] = 8'h10; rom[16'h0101] = 8'h20; rom[16'h0102] = 8'h30;
        rom[16'h0200] = 8'h55; rom[16'h0201] = 8'h66;
        rom[16'hFFFF] = 8'hAA; rom[16'h0000] = 8'hBB;
        for (int a = 0; a < 128; a++) rom[16'h0300 + a] = 8'h40;

        // ---------------- reset values ----------------
        RESET = 1'b1;
        ticks(3);
        check("reset rom_addr", 32'(ROM_ADDR), 32'h0);
        check("reset sample", 32'(SAMPLE_OUT), 32'h80);
        check("reset busy", 32'(BUSY), 32'h0);
        check("reset pwm", 32'(AUDIO_PWM), 32'h0);
        RESET = 1'b0;
        ticks(2);

        // ---------------- basic playback ----------------
        play_sel2("sel2");
        ticks(2);

        // ---------------- zero-length descriptor ----------------
        trig(4'd1);
        viol = 0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("len0 busy T+%0d", k), 32'(BUSY), 32'(k <= 5));
            check($sformatf("len0 sample T+%0d", k), 32'(SAMPLE_OUT), 32'h80);
            if (ROM_ADDR >= 16'h0300) viol++;
            tick();
        end
        check("len0 start addr issued", 32'(viol), 32'd0);

        // ---------------- address wrap ----------------
        trig(4'd4);
        for (int k = 1; k <= 18; k++) begin
            if (k == 6)  check("wrap rom_addr T+6", 32'(ROM_ADDR), 32'hFFFF);
            if (k == 10) begin
                check("wrap rom_addr T+10", 32'(ROM_ADDR), 32'h0000);
                check("wrap sample T+10", 32'(SAMPLE_OUT), 32'hAA);
            end
            if (k == 14) check("wrap sample T+14", 32'(SAMPLE_OUT), 32'hBB);
            if (k == 18) begin
                check("wrap sample T+18", 32'(SAMPLE_OUT), 32'h80);
                check("wrap busy T+18", 32'(BUSY), 32'h0);
            end
            if (k < 18) tick();
        end
        ticks(2);

        // ---------------- retrigger during playback ----------------
        trig(4'd2);
        ticks(11);                                    // cycle T+12
        check("retrig sample T+12", 32'(SAMPLE_OUT), 32'h10);
        trig(4'd3);                                   // new T2 = T+12
        drops = 0;
        for (int j = 1; j <= 18; j++) begin
            if (j <= 17 && !BUSY) drops++;
            if (j == 9)  check("retrig hold T2+9", 32'(SAMPLE_OUT), 32'h10);
            if (j == 10) check("retrig sample T2+10", 32'(SAMPLE_OUT), 32'h55);
            if (j == 14) check("retrig sample T2+14", 32'(SAMPLE_OUT), 32'h66);
            if (j == 18) begin
                check("retrig sample T2+18", 32'(SAMPLE_OUT), 32'h80);
                check("retrig busy T2+18", 32'(BUSY), 32'h0);
            end
            if (j < 18) tick();
        end
        check("retrig busy drops", 32'(drops), 32'd0);
        ticks(2);

        // ---------------- retrigger on the end tick ----------------
        trig(4'd3);
        ticks(16);                                    // cycle T+17, end tick
        check("coinc sample T+17", 32'(SAMPLE_OUT), 32'h66);
        trig(4'd2);                                   // now T+18 = T'+1
        check("coinc sample T+18", 32'(SAMPLE_OUT), 32'h80);
        check("coinc busy T+18", 32'(BUSY), 32'h1);
        check("coinc rom_addr T+18", 32'(ROM_ADDR), 32'h08);
        ticks(9);                                     // T'+10
        check("coinc new sample", 32'(SAMPLE_OUT), 32'h10);
        ticks(14);

        // ---------------- PWM duty 0x40 ----------------
        trig(4'd5);
        ticks(11);                                    // T+12
        check("pwm40 sample", 32'(SAMPLE_OUT), 32'h40);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cnt += int'(AUDIO_PWM);
            tick();
        end
        check("pwm40 high count", 32'(cnt), 32'd64);

        // ---------------- PWM duty 0x00 (via retrigger) ----------------
        trig(4'd6);
        ticks(11);
        check("pwm00 sample", 32'(SAMPLE_OUT), 32'h00);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cnt += int'(AUDIO_PWM);
            tick();
        end
        check("pwm00 high count", 32'(cnt), 32'd0);

        // ---------------- reset mid-playback ----------------
        check("midplay busy", 32'(BUSY), 32'h1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("midreset sample", 32'(SAMPLE_OUT), 32'h80);
        check("midreset busy", 32'(BUSY), 32'h0);
        check("midreset rom_addr", 32'(ROM_ADDR), 32'h0);
        check("midreset pwm", 32'(AUDIO_PWM), 32'h0);
        ticks(8);
        check("postreset busy", 32'(BUSY), 32'h0);
        check("postreset sample", 32'(SAMPLE_OUT), 32'h80);

        // ---------------- playback after reset ----------------
        play_sel2("after reset");
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_sample_player.md
Name: audio_sample_player

Overview:
Receiving end of the game-event audio interface. Accepts a one-cycle TRIGGER plus SAMPLE_SELECT from the game controller. Looks up the selected sample's start address and length in a descriptor table held in the shared sample ROM. Streams the 8-bit unsigned sample bytes at a fixed playback rate and drives a 1-bit PWM speaker output.

Parameters:
SAMPLE_BITS, 4, width of SAMPLE_SELECT; up to 2^SAMPLE_BITS samples
ADDR_BITS, 16, sample ROM address width
DESC_BASE, 0, ROM address of descriptor 0
CLK_DIV, 3125, clocks per output sample (16 kHz at 50 MHz); must be >= 4

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
SAMPLE_SELECT  in  SAMPLE_BITS  sample index; sampled only in the cycle TRIGGER is high
TRIGGER  in  1  one-cycle start pulse
ROM_ADDR  out  ADDR_BITS  sample ROM address (registered)
ROM_DATA  in  8  ROM read data; equals mem[ROM_ADDR of previous cycle]
SAMPLE_OUT  out  8  current unsigned sample value; 0x80 = silence
AUDIO_PWM  out  1  PWM speaker drive
BUSY  out  1  high while fetching or playing

Behaviour:
- Reset values: ROM_ADDR=0, SAMPLE_OUT=0x80, BUSY=0, state IDLE, PWM counter=0, AUDIO_PWM=0.
- Descriptor for index s occupies 4 bytes at DESC_BASE+4*s, big-endian: start[15:8], start[7:0], length[15:8], length[7:0]. Length is in bytes.
- States: IDLE -> FETCH -> PLAY -> IDLE.
- IDLE to FETCH: TRIGGER seen at cycle T.
  - Latch s.
  - BUSY=1 from T+1.
  - ROM_ADDR = DESC_BASE+4s+0..3 on cycles T+1..T+4.
  - Bytes captured from ROM_DATA on T+2..T+5.
- FETCH complete: state is PLAY at T+6, with ROM_ADDR=start, remaining=length, rate counter=0.
  - If length==0, state returns to IDLE at T+6 instead; BUSY=0 at T+6; SAMPLE_OUT stays 0x80.
- PLAY:
  - Rate counter counts 0..CLK_DIV-1 and wraps.
  - At each wrap (a tick): if remaining!=0, SAMPLE_OUT <= ROM_DATA (prefetched byte at current pointer), pointer+1, ROM_ADDR <= pointer+1, remaining-1.
  - If remaining==0 at a tick: SAMPLE_OUT <= 0x80, state to IDLE, BUSY=0.
  - The first sample therefore appears at T+6+CLK_DIV; the last sample is held for exactly CLK_DIV cycles.
- Pointer arithmetic is ADDR_BITS wide and wraps modulo 2^ADDR_BITS. Descriptor address 4*s is truncated to ADDR_BITS.
- Retrigger: TRIGGER in any state (FETCH or PLAY) aborts the current activity and restarts FETCH with the new select, same timing as from IDLE. The latest trigger wins.
  - SAMPLE_OUT holds its current value until the new sample's first tick.
  - BUSY stays high throughout.
- TRIGGER coincident with a PLAY end tick: the retrigger wins. SAMPLE_OUT <= 0x80 and state goes to FETCH.
- SAMPLE_SELECT is ignored when TRIGGER is low.
- PWM:
  - 8-bit free-running counter pwm_cnt increments every clock and wraps 255->0.
  - AUDIO_PWM registered: AUDIO_PWM <= (pwm_cnt < SAMPLE_OUT).
  - Duty cycle is SAMPLE_OUT/256; 0x00 gives constant low.
- RESET mid-playback: next cycle all outputs at reset values; playback abandoned.

Test Plan:
- Descriptor 2 = {0x01,0x00,0x00,0x03}, ROM[0x100..0x102] = 0x10,0x20,0x30, CLK_DIV=4, TRIGGER with select 2 at T:
  - ROM_ADDR = 0x08..0x0B on T+1..T+4.
  - SAMPLE_OUT = 0x10 at T+10, 0x20 at T+14, 0x30 at T+18, 0x80 at T+22.
  - BUSY high T+1..T+21.
- Descriptor length 0 -> BUSY high T+1..T+5 only; SAMPLE_OUT stays 0x80; no ROM_ADDR >= start issued.
- Retrigger select 3 (length 2) at T+12 during sample 2 playback:
  - SAMPLE_OUT holds 0x10 until T+12+10.
  - Then sample-3 bytes play; BUSY never drops.
- Start 0xFFFF, length 2 -> bytes fetched from 0xFFFF then 0x0000.
- SAMPLE_OUT=0x40 held -> AUDIO_PWM high 64 of every 256 cycles.
- SAMPLE_OUT=0x00 -> AUDIO_PWM constantly low.
- RESET asserted mid-PLAY -> next cycle SAMPLE_OUT=0x80, BUSY=0, ROM_ADDR=0.
- Later TRIGGER after RESET -> plays normally.
